// File: rtl/card_mem_pkg.sv
// Shared layout of the card-list RAM: widths, node word fields and the null address.
// Used by the allocator, free_list and the list operators.
package card_mem_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ALLOC_BIT = 31;
  localparam int unsigned NEXT_LSB  = 0;
  localparam int unsigned NEXT_MSB  = 9;
  localparam int unsigned VALUE_LSB = 20;
  localparam int unsigned VALUE_MSB = 25;

  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  // One card node word as stored in RAM.
  typedef struct packed {
    logic                         alloc;
    logic [ALLOC_BIT-VALUE_MSB-2:0] rsvd_hi;
    logic [VALUE_MSB-VALUE_LSB:0] value;
    logic [VALUE_LSB-NEXT_MSB-2:0] rsvd_lo;
    logic [NEXT_MSB-NEXT_LSB:0]   next;
  } card_node_t;

  function automatic logic node_allocated(input logic [DATA_W-1:0] word);
    return word[ALLOC_BIT];
  endfunction

  function automatic logic [ADDR_W-1:0] node_next(input logic [DATA_W-1:0] word);
    return ADDR_W'(word[NEXT_MSB:NEXT_LSB]);
  endfunction

endpackage

// File: rtl/free_list.sv
// Walks a linked list of card nodes and zeroes each node word, releasing it.
// Aborts with error on a node that is already free or when the node budget runs out.
module free_list
  import card_mem_pkg::*;
#(
  parameter int unsigned MAX_NODES = 1023
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] head_addr,
  output logic              finished_freeing,
  output logic [ADDR_W-1:0] freed_count,
  output logic              error,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_clock,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WR    = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_NODES);

  state_t            state, state_d;
  logic [ADDR_W-1:0] cur, cur_d;
  logic [ADDR_W-1:0] nxt, nxt_d;
  logic [ADDR_W-1:0] freed_count_d;
  logic              error_d;
  logic              finished_d;
  logic [ADDR_W-1:0] ram_address_d;
  logic              ram_wren_d;
  logic [ADDR_W-1:0] count_inc;

  card_node_t node;
  logic       unused_node_bits;

  assign ram_clock = clock;
  assign ram_data  = '0;
  assign node      = card_node_t'(ram_q);
  assign count_inc = freed_count + ADDR_W'(1);
  assign unused_node_bits = ^{node.rsvd_hi, node.value, node.rsvd_lo};

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      cur              <= NULL_ADDR;
      nxt              <= NULL_ADDR;
      freed_count      <= '0;
      error            <= 1'b0;
      finished_freeing <= 1'b1;
      ram_address      <= NULL_ADDR;
      ram_wren         <= 1'b0;
    end else begin
      state            <= state_d;
      cur              <= cur_d;
      nxt              <= nxt_d;
      freed_count      <= freed_count_d;
      error            <= error_d;
      finished_freeing <= finished_d;
      ram_address      <= ram_address_d;
      ram_wren         <= ram_wren_d;
    end
  end

  // Next-state and next-register values.
  always_comb begin
    state_d       = state;
    cur_d         = cur;
    nxt_d         = nxt;
    freed_count_d = freed_count;
    error_d       = error;
    finished_d    = finished_freeing;
    ram_address_d = ram_address;
    ram_wren_d    = ram_wren;

    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          cur_d         = head_addr;
          freed_count_d = '0;
          error_d       = 1'b0;
          finished_d    = 1'b0;
          state_d       = (head_addr == NULL_ADDR) ? ST_DONE : ST_RD;
        end
      end

      ST_RD: begin
        ram_address_d = cur;
        ram_wren_d    = 1'b0;
        state_d       = ST_WAIT;
      end

      ST_WAIT: begin
        state_d = ST_CHECK;
      end

      // An unallocated node means it was already released: abort without writing.
      ST_CHECK: begin
        if (!node_allocated(ram_q)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          nxt_d      = node_next(ram_q);
          ram_wren_d = 1'b1;
          state_d    = ST_WR;
        end
      end

      ST_WR: begin
        ram_wren_d    = 1'b0;
        freed_count_d = count_inc;
        if (nxt == NULL_ADDR) begin
          state_d = ST_DONE;
        end else if (count_inc == MAX_CNT) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cur_d   = nxt;
          state_d = ST_RD;
        end
      end

      // Hold here until enable drops so a held request frees only once.
      ST_DONE: begin
        finished_d = 1'b1;
        if (!enable) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list against a list-walking reference model.
module tb_free_list;

  localparam int unsigned MAXN = 4;

  logic        clock;
  logic        resetn;
  logic        enable;
  logic [9:0]  head_addr;
  logic        finished_freeing;
  logic [9:0]  freed_count;
  logic        error;
  logic [9:0]  ram_address;
  logic        ram_clock;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q;

  free_list #(.MAX_NODES(MAXN)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .head_addr(head_addr),
    .finished_freeing(finished_freeing), .freed_count(freed_count), .error(error),
    .ram_address(ram_address), .ram_clock(ram_clock), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RAM: one registered read stage, plus a bench-side load port.
  logic [31:0] ram [1024];
  logic        tb_we;
  logic [9:0]  tb_wa;
  logic [31:0] tb_wd;
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  always @(posedge clock) begin
    if (ram_wren) begin
      ram[ram_address] <= ram_data;
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_data);
    end else if (tb_we) begin
      ram[tb_wa] <= tb_wd;
    end
    ram_q <= ram[ram_address];
  end

  // Reference memory image and expected write order.
  logic [31:0] ref_mem [1024];
  logic [9:0]  exp_wr [$];
  int          n_cmp;
  int          n_fail;
  string       cur_op;

  task automatic check(input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", cur_op, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    tick();
    tb_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic logic [31:0] mk_node(input bit alloc, input logic [9:0] nxt);
    logic [31:0] w;
    w = '0;
    w[31] = alloc;
    w[25:20] = 6'($urandom_range(0, 63));
    w[9:0] = nxt;
    return w;
  endfunction

  // Reference: follow the list, releasing allocated nodes, stopping on null,
  // an already-free node, or once MAXN nodes have been released.
  task automatic model(input logic [9:0] head, output int cnt, output bit err, output bit df);
    logic [9:0]  c;
    logic [31:0] w;
    cnt = 0; err = 0; df = 0;
    exp_wr.delete();
    c = head;
    while (c != 10'd0) begin
      w = ref_mem[c];
      if (!w[31]) begin
        err = 1; df = 1;
        break;
      end
      exp_wr.push_back(c);
      ref_mem[c] = '0;
      cnt++;
      if (w[9:0] == 10'd0) break;
      if (cnt == int'(MAXN)) begin
        err = 1;
        break;
      end
      c = w[9:0];
    end
  endtask

  // Cycles counted from the assertion of enable (the sample edge is cycle 1).
  task automatic run_op(input logic [9:0] head);
    int ecnt, base, cyc, exp_cyc, diffs, nw;
    bit eerr, edf;
    model(head, ecnt, eerr, edf);
    exp_cyc = (head == 10'd0) ? 2 : 4 * ecnt + 3 * int'(edf) + 2;
    base = wr_addr.size();
    enable = 1'b1;
    head_addr = head;
    tick();
    cyc = 1;
    enable = 1'b0;
    head_addr = 10'($urandom_range(0, 1023));
    check("busy", 32'(finished_freeing), 32'd0);
    while (!finished_freeing && cyc < 200) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_cyc));
    check("freed_count", 32'(freed_count), 32'(ecnt));
    check("error", 32'(error), 32'(eerr));
    nw = wr_addr.size() - base;
    check("n_writes", 32'(nw), 32'(exp_wr.size()));
    for (int i = 0; i < nw && i < exp_wr.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[base + i]), 32'(exp_wr[i]));
      check($sformatf("wr_data[%0d]", i), wr_data[base + i], 32'd0);
    end
    diffs = 0;
    for (int a = 0; a < 1024; a++) if (ram[a] !== ref_mem[a]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);
    tick();
  endtask

  // Loads a list at the given distinct addresses; the last node ends in null.
  task automatic load_list(input logic [9:0] addrs [$]);
    for (int i = 0; i < addrs.size(); i++)
      poke(addrs[i], mk_node(1'b1, (i + 1 < addrs.size()) ? addrs[i + 1] : 10'd0));
  endtask

  initial begin
    logic [9:0] lst [$];
    logic [9:0] a;
    int len, mode, found;
    n_cmp = 0; n_fail = 0;
    resetn = 1'b0; enable = 1'b0; head_addr = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    cur_op = "reset";
    repeat (3) tick();
    check("finished", 32'(finished_freeing), 32'd1);
    check("freed_count", 32'(freed_count), 32'd0);
    check("error", 32'(error), 32'd0);
    check("ram_address", 32'(ram_address), 32'd0);
    check("ram_wren", 32'(ram_wren), 32'd0);
    check("ram_clock", 32'(ram_clock), 32'(clock));
    resetn = 1'b1;
    for (int i = 0; i < 1024; i++) poke(10'(i), 32'd0);

    cur_op = "empty";
    run_op(10'd0);

    cur_op = "three_node";
    poke(10'd5, 32'h8000_0009); poke(10'd9, 32'h8000_000C); poke(10'd12, 32'h8000_0000);
    run_op(10'd5);

    cur_op = "double_free";
    poke(10'd7, 32'h8000_0003); poke(10'd3, 32'h0000_0000);
    run_op(10'd7);

    cur_op = "self_loop";
    poke(10'd2, 32'h8000_0002);
    run_op(10'd2);

    cur_op = "two_cycle";
    poke(10'd2, 32'h8000_0004); poke(10'd4, 32'h8000_0002);
    run_op(10'd2);

    cur_op = "six_node";
    lst = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd500, 10'd600};
    load_list(lst);
    run_op(10'd100);

    for (int t = 0; t < 25; t++) begin
      cur_op = $sformatf("rand%0d", t);
      len = $urandom_range(0, 6);
      mode = $urandom_range(0, 3);
      lst.delete();
      while (lst.size() < len) begin
        a = 10'($urandom_range(1, 1023));
        found = 0;
        foreach (lst[k]) if (lst[k] == a) found = 1;
        if (found == 0) lst.push_back(a);
      end
      load_list(lst);
      if (len > 0 && mode == 1) begin
        a = lst[$urandom_range(0, len - 1)];
        poke(a, mk_node(1'b0, ref_mem[a][9:0]));
      end else if (len > 0 && mode == 2) begin
        a = lst[len - 1];
        poke(a, mk_node(1'b1, lst[$urandom_range(0, len - 1)]));
      end
      run_op((len > 0) ? lst[0] : 10'd0);
    end

    cur_op = "reset_mid_op";
    lst = '{10'd40, 10'd41, 10'd42};
    load_list(lst);
    enable = 1'b1; head_addr = 10'd40;
    tick();
    enable = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (ram_wren && ram_address == 10'd41) found = 1;
      else tick();
    end
    check("reached_wr2", 32'(found), 32'd1);
    resetn = 1'b0;
    #1;
    check("ram_wren", 32'(ram_wren), 32'd0);
    check("finished", 32'(finished_freeing), 32'd1);
    check("freed_count", 32'(freed_count), 32'd0);
    check("error", 32'(error), 32'd0);
    check("ram_address", 32'(ram_address), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("node1", ram[40], 32'd0);
    check("node2_alloc", 32'(ram[41][31]), 32'd1);
    check("node3_alloc", 32'(ram[42][31]), 32'd1);
    ref_mem[40] = '0;

    cur_op = "held_enable";
    poke(10'd77, mk_node(1'b1, 10'd0));
    found = wr_addr.size();
    enable = 1'b1; head_addr = 10'd77;
    repeat (20) tick();
    check("n_writes", 32'(wr_addr.size() - found), 32'd1);
    check("finished", 32'(finished_freeing), 32'd1);
    check("freed_count", 32'(freed_count), 32'd1);
    check("error", 32'(error), 32'd0);
    check("node_freed", ram[77], 32'd0);
    ref_mem[77] = '0;
    enable = 1'b0;
    tick();
    cur_op = "rearm";
    poke(10'd78, mk_node(1'b1, 10'd0));
    run_op(10'd78);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
